// File: rtl/measure_pkg.sv
// Shared constants, state encoding and helpers for the measurement sequencer.
package measure_pkg;

  localparam logic [1:0] MEAS_NONE = 2'd0;
  localparam logic [1:0] MEAS_X    = 2'd1;
  localparam logic [1:0] MEAS_Y    = 2'd2;

  typedef enum logic [1:0] {StIdle, StMul, StSat, StZero} state_t;

  localparam int unsigned A_W       = 11;
  localparam int unsigned B_W       = 16;
  localparam int unsigned P_W       = 27;
  localparam int unsigned MUL_ITERS = 16;

  localparam int unsigned SAT_MAX_DEFAULT = 9999;

  function automatic logic [A_W-1:0] abs_diff(input logic [A_W-1:0] x,
                                               input logic [A_W-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// 11x16 unsigned shift-add multiplier; one multiplier bit per cycle, LSB first,
// fixed 16-cycle run after load.
module shift_add_mul
  import measure_pkg::*;
(
  input  logic           clock,
  input  logic           resetn,
  input  logic           load,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [P_W-1:0] product
);

  localparam int unsigned   CW   = $clog2(MUL_ITERS);
  localparam logic [CW-1:0] LAST = CW'(MUL_ITERS - 1);

  logic           r_busy;
  logic [CW-1:0]  r_count;
  logic [P_W-1:0] r_mcand;
  logic [B_W-1:0] r_mplier;
  logic [P_W-1:0] r_acc;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_busy   <= 1'b0;
      r_count  <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (load) begin
      r_busy   <= 1'b1;
      r_count  <= '0;
      r_mcand  <= P_W'(a);
      r_mplier <= b;
      r_acc    <= '0;
    end else if (r_busy) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
      if (r_count == LAST) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign busy    = r_busy;
  // High during the final iteration: product is complete after this edge.
  assign done    = r_busy && (r_count == LAST);
  assign product = r_acc;

endmodule

// File: rtl/measure_sequencer.sv
// Cursor measurement sequencer: operand select, iterative scaling, saturation to
// the display range, driven by a start pulse or the refresh timer.
module measure_sequencer
  import measure_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 2500000,
  parameter int unsigned SAT_MAX        = SAT_MAX_DEFAULT
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        autoRun,
  input  logic [10:0] cursorx1,
  input  logic [10:0] cursorx2,
  input  logic [10:0] cursory1,
  input  logic [10:0] cursory2,
  input  logic [5:0]  sampleAdjust1,
  input  logic [5:0]  sampleAdjust2,
  input  logic [3:0]  shiftDown1,
  input  logic [3:0]  shiftDown2,
  input  logic        waveSel,
  input  logic [1:0]  measurement,
  output logic        busy,
  output logic        done,
  output logic [13:0] num,
  output logic        overflow
);

  localparam int unsigned    TW         = $clog2(REFRESH_CYCLES);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(REFRESH_CYCLES - 1);
  localparam logic [P_W-1:0] SAT_P      = P_W'(SAT_MAX);
  localparam logic [13:0]    SAT_NUM    = 14'(SAT_MAX);

  logic [TW-1:0]  r_timer;
  logic           w_tick;
  logic           w_trigger;

  state_t         r_state;
  state_t         w_state_d;

  logic [5:0]     w_sa;
  logic [3:0]     w_sd;
  logic [A_W-1:0] w_op_a;
  logic [B_W-1:0] w_op_b;
  logic           w_is_mul;
  logic           w_accept;
  logic           w_load;

  logic           w_mul_busy;
  logic           w_mul_done;
  logic [P_W-1:0] w_product;

  logic           r_busy;
  logic           r_done;
  logic [13:0]    r_num;
  logic           r_ovf;
  logic           w_busy_d;
  logic           w_done_d;
  logic [13:0]    w_num_d;
  logic           w_ovf_d;

  // Refresh timer keeps running while a measurement is in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_timer <= '0;
    end else if (!autoRun || w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign w_tick    = autoRun && (r_timer == TIMER_LAST);
  assign w_trigger = start || w_tick;
  assign w_accept  = (r_state == StIdle) && w_trigger && !w_mul_busy;

  always_comb begin
    w_sa     = waveSel ? sampleAdjust2 : sampleAdjust1;
    w_sd     = waveSel ? shiftDown2 : shiftDown1;
    w_op_a   = '0;
    w_op_b   = '0;
    w_is_mul = 1'b0;
    unique case (measurement)
      MEAS_X: begin
        w_op_a   = abs_diff(cursorx2, cursorx1);
        w_op_b   = B_W'({1'b0, w_sa} + 7'd1);
        w_is_mul = 1'b1;
      end
      MEAS_Y: begin
        w_op_a   = abs_diff(cursory2, cursory1);
        w_op_b   = B_W'(1) << w_sd;
        w_is_mul = 1'b1;
      end
      MEAS_NONE: w_is_mul = 1'b0;
      default:   w_is_mul = 1'b0;
    endcase
  end

  assign w_load = w_accept && w_is_mul;

  shift_add_mul u_mul (
    .clock   (clock),
    .resetn  (resetn),
    .load    (w_load),
    .a       (w_op_a),
    .b       (w_op_b),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_product)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = w_is_mul ? StMul : StZero;
      StMul:   if (w_mul_done) w_state_d = StSat;
      StSat:   w_state_d = StIdle;
      StZero:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_busy_d = (w_state_d != StIdle);
    w_done_d = (r_state == StSat) || (r_state == StZero);
    w_num_d  = r_num;
    w_ovf_d  = r_ovf;
    if (r_state == StSat) begin
      if (w_product > SAT_P) begin
        w_num_d = SAT_NUM;
        w_ovf_d = 1'b1;
      end else begin
        w_num_d = w_product[13:0];
        w_ovf_d = 1'b0;
      end
    end else if (r_state == StZero) begin
      w_num_d = '0;
      w_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_num  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_busy <= w_busy_d;
      r_done <= w_done_d;
      r_num  <= w_num_d;
      r_ovf  <= w_ovf_d;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign num      = r_num;
  assign overflow = r_ovf;

endmodule
